// File: rtl/oven_zone_thermal.sv
// Multi-zone oven thermal model with settle-qualified preheat detection.
// Each zone integrates a simulated temperature on a divided tick. The zone
// heats while its heater is enabled and decays toward ambient otherwise.
// A four-state FSM asserts preheated once every zone has stayed inside the
// tolerance band for SETTLE_TICKS consecutive ticks.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   targetTemp    shared setpoint for all zones
//   tempInputDone setpoint valid; low forces the FSM to idle
//   heat          per-zone heater enable (bit z drives zone z)
//   currentTemp   registered zone temperatures, zone z at [z*WIDTH +: WIDTH]
//   zoneInBand    per-zone in-band flag (combinational)
//   preheated     registered, high only in the ready state
//   overTemp      high while any zone sits at MAX_TEMP
module oven_zone_thermal #(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned ZONES        = 2,
    parameter int unsigned AMBIENT      = 65,
    parameter int unsigned MAX_TEMP     = 550,
    parameter int unsigned HEAT_STEP    = 2,
    parameter int unsigned COOL_STEP    = 1,
    parameter int unsigned TOLERANCE    = 2,
    parameter int unsigned SETTLE_TICKS = 4,
    parameter int unsigned TICK_DIV     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       targetTemp,
    input  logic                   tempInputDone,
    input  logic [ZONES-1:0]       heat,
    output logic [ZONES*WIDTH-1:0] currentTemp,
    output logic [ZONES-1:0]       zoneInBand,
    output logic                   preheated,
    output logic                   overTemp
);

    localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SettleW = $clog2(SETTLE_TICKS + 1);

    localparam logic [TickW-1:0]   TickLast   = TickW'(TICK_DIV - 1);
    localparam logic [SettleW-1:0] SettleDone = SettleW'(SETTLE_TICKS);
    localparam logic [WIDTH-1:0]   Amb        = WIDTH'(AMBIENT);
    localparam logic [WIDTH-1:0]   MaxT       = WIDTH'(MAX_TEMP);
    localparam logic [WIDTH:0]     AmbW       = (WIDTH+1)'(AMBIENT);
    localparam logic [WIDTH:0]     MaxW       = (WIDTH+1)'(MAX_TEMP);
    localparam logic [WIDTH:0]     HeatW      = (WIDTH+1)'(HEAT_STEP);
    localparam logic [WIDTH:0]     CoolW      = (WIDTH+1)'(COOL_STEP);
    localparam logic [WIDTH:0]     TolW       = (WIDTH+1)'(TOLERANCE);
    localparam logic [WIDTH:0]     FloorW     = (WIDTH+1)'(AMBIENT + COOL_STEP);

    typedef enum logic [1:0] {StIdle, StRamp, StSettle, StReady} state_e;

    // Tick divider
    logic [TickW-1:0] tick_cnt_q;
    logic             tick;

    assign tick = (tick_cnt_q == TickLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    // Zone temperatures
    logic [WIDTH-1:0] temp_q [ZONES];
    logic [WIDTH-1:0] temp_d [ZONES];

    // All arithmetic at WIDTH+1 bits so neither step can wrap.
    function automatic logic [WIDTH-1:0] next_temp(input logic [WIDTH-1:0] t, input logic on);
        logic [WIDTH:0] cur;
        logic [WIDTH:0] nxt;
        cur = {1'b0, t};
        if (on) begin
            nxt = cur + HeatW;
            if (nxt > MaxW) nxt = MaxW;
            // Only reachable from a zone that somehow sits below ambient.
            if (nxt < AmbW) nxt = AmbW;
        end else if (cur <= FloorW) begin
            nxt = AmbW;
        end else begin
            nxt = cur - CoolW;
        end
        return nxt[WIDTH-1:0];
    endfunction

    always_comb begin
        for (int z = 0; z < ZONES; z++) begin
            temp_d[z] = tick ? next_temp(temp_q[z], tempInputDone & heat[z]) : temp_q[z];
        end
    end

    always_ff @(posedge clk) begin
        for (int z = 0; z < ZONES; z++) begin
            if (reset) begin
                temp_q[z] <= Amb;
            end else begin
                temp_q[z] <= temp_d[z];
            end
        end
    end

    for (genvar z = 0; z < ZONES; z++) begin : g_out
        assign currentTemp[z*WIDTH +: WIDTH] = temp_q[z];
    end

    // Band test; low bound floors at zero, high bound has a spare bit.
    logic [WIDTH:0] band_lo;
    logic [WIDTH:0] band_hi;
    logic           all_in_band;

    always_comb begin
        band_lo  = ({1'b0, targetTemp} < TolW) ? '0 : ({1'b0, targetTemp} - TolW);
        band_hi  = {1'b0, targetTemp} + TolW;
        overTemp = 1'b0;
        for (int z = 0; z < ZONES; z++) begin
            zoneInBand[z] = ({1'b0, temp_q[z]} >= band_lo) && ({1'b0, temp_q[z]} <= band_hi);
            overTemp      = overTemp | (temp_q[z] == MaxT);
        end
    end

    assign all_in_band = &zoneInBand;

    // Preheat FSM; band flags are sampled on the pre-update temperatures.
    state_e             state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic               preheated_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (!tempInputDone) begin
            state_d  = StIdle;
            settle_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StRamp;
                    settle_d = '0;
                end
                StRamp: begin
                    if (tick && all_in_band) begin
                        settle_d = SettleW'(1);
                        state_d  = (SETTLE_TICKS == 1) ? StReady : StSettle;
                    end
                end
                StSettle: begin
                    if (tick) begin
                        if (all_in_band) begin
                            settle_d = settle_q + SettleW'(1);
                            if (settle_d == SettleDone) state_d = StReady;
                        end else begin
                            settle_d = '0;
                            state_d  = StRamp;
                        end
                    end
                end
                StReady: begin
                    if (tick && !all_in_band) begin
                        settle_d = '0;
                        state_d  = StRamp;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    settle_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            preheated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            preheated_q <= (state_d == StReady);
        end
    end

    assign preheated = preheated_q;

endmodule

// File: tb/tb_oven_zone_thermal.sv
// Bench for oven_zone_thermal: one instance with TICK_DIV=1 and one with
// TICK_DIV=3 share stimulus; a behavioural model tracks both.
module tb_oven_zone_thermal;

    localparam int W = 10;
    localparam int Z = 2;
    localparam int S = 4;
    localparam int AMB = 65;
    localparam int MAXT = 550;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   targetTemp;
    logic           tempInputDone;
    logic [Z-1:0]   heat;
    logic [Z*W-1:0] cur_a, cur_b;
    logic [Z-1:0]   band_a, band_b;
    logic           pre_a, pre_b, ot_a, ot_b;

    always #5 clk = ~clk;

    oven_zone_thermal #(.TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .targetTemp(targetTemp), .tempInputDone(tempInputDone),
        .heat(heat), .currentTemp(cur_a), .zoneInBand(band_a), .preheated(pre_a),
        .overTemp(ot_a)
    );

    oven_zone_thermal #(.TICK_DIV(3)) dut_b (
        .clk(clk), .reset(reset), .targetTemp(targetTemp), .tempInputDone(tempInputDone),
        .heat(heat), .currentTemp(cur_b), .zoneInBand(band_b), .preheated(pre_b),
        .overTemp(ot_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic bit in_band(input int t, input int tgt);
        int lo;
        lo = (tgt < 2) ? 0 : tgt - 2;
        return (t >= lo) && (t <= tgt + 2);
    endfunction

    // Model: preheated means "setpoint held since last clock, and the last
    // S ticks all had every zone in band".
    int  m_temp [2][Z];
    int  m_tc [2];
    bit  m_armed [2];
    int  m_streak [2];
    bit  m_pre [2];
    int  div [2] = '{1, 3};
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int z = 0; z < Z; z++) m_temp[i][z] = AMB;
                m_tc[i] = 0;
                m_armed[i] = 1'b0;
                m_streak[i] = 0;
                m_pre[i] = 1'b0;
            end else begin
                bit tk;
                bit all;
                tk = (m_tc[i] == div[i] - 1);
                all = 1'b1;
                for (int z = 0; z < Z; z++) all = all & in_band(m_temp[i][z], int'(targetTemp));
                if (!tempInputDone) begin
                    m_armed[i] = 1'b0;
                    m_streak[i] = 0;
                end else begin
                    if (m_armed[i] && tk) m_streak[i] = all ? ((m_streak[i] < S) ? m_streak[i] + 1 : S) : 0;
                    m_armed[i] = 1'b1;
                end
                m_pre[i] = m_armed[i] && (m_streak[i] >= S);
                if (tk) begin
                    for (int z = 0; z < Z; z++) begin
                        if (tempInputDone && heat[z]) begin
                            m_temp[i][z] = (m_temp[i][z] + 2 > MAXT) ? MAXT : m_temp[i][z] + 2;
                        end else begin
                            m_temp[i][z] = (m_temp[i][z] <= AMB + 1) ? AMB : m_temp[i][z] - 1;
                        end
                    end
                end
                m_tc[i] = tk ? 0 : m_tc[i] + 1;
            end
        end
        if (reset) model_valid = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    int seen_pre_a = 0;
    int seen_pre_b = 0;

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                bit ot;
                ot = 1'b0;
                for (int z = 0; z < Z; z++) begin
                    int gt;
                    int gb;
                    gt = (i == 0) ? int'(cur_a[z*W +: W]) : int'(cur_b[z*W +: W]);
                    gb = (i == 0) ? int'(band_a[z]) : int'(band_b[z]);
                    chk($sformatf("temp i%0d z%0d", i, z), gt, m_temp[i][z]);
                    chk($sformatf("band i%0d z%0d", i, z), gb, int'(in_band(m_temp[i][z], int'(targetTemp))));
                    ot = ot | (m_temp[i][z] == MAXT);
                end
                chk($sformatf("preheated i%0d", i), (i == 0) ? int'(pre_a) : int'(pre_b), int'(m_pre[i]));
                chk($sformatf("overTemp i%0d", i), (i == 0) ? int'(ot_a) : int'(ot_b), int'(ot));
            end
            if (pre_a) seen_pre_a++;
            if (pre_b) seen_pre_b++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic lit_a(input string name, input int t0, input int t1, input int pre);
        chk({name, " a z0"}, int'(cur_a[0 +: W]), t0);
        chk({name, " a z1"}, int'(cur_a[W +: W]), t1);
        chk({name, " a pre"}, int'(pre_a), pre);
    endtask

    initial begin
        int pol;
        reset = 1'b1;
        tempInputDone = 1'b0;
        heat = 2'b11;
        targetTemp = '0;
        cyc();
        cyc();
        lit_a("reset", 65, 65, 0);
        chk("reset b z0", int'(cur_b[0 +: W]), 65);
        chk("reset ot", int'(ot_a), 0);
        reset = 1'b0;
        repeat (10) cyc();
        lit_a("idle", 65, 65, 0);
        chk("idle b z1", int'(cur_b[W +: W]), 65);

        // Ramp and settle on the undivided instance.
        targetTemp = 10'd71;
        tempInputDone = 1'b1;
        heat = 2'b11;
        cyc(); lit_a("ramp1", 67, 67, 0);
        cyc(); lit_a("ramp2", 69, 69, 0);
        cyc(); lit_a("ramp3", 71, 71, 0);
        heat = 2'b00;
        cyc(); lit_a("cool1", 70, 70, 0);
        cyc(); lit_a("cool2", 69, 69, 0);
        cyc(); lit_a("ready", 68, 68, 1);
        cyc(); lit_a("bandloss", 67, 67, 0);

        // Reset on the same edge as an in-band settle tick.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        heat = 2'b11;
        cyc(); cyc(); cyc();
        heat = 2'b00;
        cyc();
        reset = 1'b1;
        cyc();
        lit_a("reset_wins", 65, 65, 0);
        reset = 1'b0;
        tempInputDone = 1'b0;
        cyc();

        // Randomised bang-bang regulation with aborts, resets and target moves.
        targetTemp = 10'd80;
        tempInputDone = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            pol = (k / 500) % 2;
            if ($urandom_range(0, 199) == 0) begin
                targetTemp = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 1))
                                                          : W'($urandom_range(60, 140));
            end
            if (tempInputDone) tempInputDone = ($urandom_range(0, 99) != 0);
            else tempInputDone = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 299) == 0);
            for (int z = 0; z < Z; z++) begin
                heat[z] = (m_temp[pol][z] < int'(targetTemp)) ^ ($urandom_range(0, 19) == 0);
            end
            cyc();
        end
        reset = 1'b0;
        chk("preheat seen a", int'(seen_pre_a > 0), 1);
        chk("preheat seen b", int'(seen_pre_b > 0), 1);

        // Saturation, then cool to the floor.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        targetTemp = 10'd550;
        tempInputDone = 1'b1;
        heat = 2'b11;
        repeat (760) cyc();
        lit_a("sat", 550, 550, 1);
        chk("sat b z0", int'(cur_b[0 +: W]), 550);
        chk("sat ot a", int'(ot_a), 1);
        chk("sat ot b", int'(ot_b), 1);
        repeat (6) cyc();
        chk("sat hold b z1", int'(cur_b[W +: W]), 550);
        heat = 2'b00;
        repeat (1480) cyc();
        lit_a("floor", 65, 65, 0);
        chk("floor b z0", int'(cur_b[0 +: W]), 65);
        chk("floor ot a", int'(ot_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oven_zone_thermal.md
# oven_zone_thermal

Parametrised multi-zone oven thermal model with settle-qualified preheat detection. Each zone holds a simulated temperature that rises while its heater is on and decays toward ambient otherwise, updated on a programmable tick. A small state machine reports `preheated` only after every zone has stayed inside the tolerance band for a set number of consecutive ticks. The block sits between the user-input/target-entry logic and the cook-control sequencer, and is the generalised successor of the single-zone temperature model.

## Interface
- `WIDTH`, 10: temperature word width, unsigned °F.
- `ZONES`, 2: number of independent heating zones, ≥1.
- `AMBIENT`, 65: floor temperature, reset value of every zone.
- `MAX_TEMP`, 550: saturation ceiling, must be < 2^WIDTH.
- `HEAT_STEP`, 2: increment per tick with heater on.
- `COOL_STEP`, 1: decrement per tick with heater off.
- `TOLERANCE`, 2: half-width of the in-band window.
- `SETTLE_TICKS`, 4: consecutive all-in-band ticks required for preheat, ≥1.
- `TICK_DIV`, 1: clocks per thermal update, ≥1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `targetTemp` input WIDTH: shared setpoint for all zones.
- `tempInputDone` input 1: setpoint valid; low forces IDLE.
- `heat` input ZONES: per-zone heater enable, bit z drives zone z.
- `currentTemp` output ZONES*WIDTH: zone z at bits [z*WIDTH +: WIDTH], registered.
- `zoneInBand` output ZONES: per-zone in-band flag, combinational from `currentTemp` and `targetTemp`.
- `preheated` output 1: registered, high only in READY.
- `overTemp` output 1: high while any zone equals MAX_TEMP.

## Operation
- Tick: counter 0..TICK_DIV-1, `tick` asserted when count == TICK_DIV-1, then wraps to 0. TICK_DIV=1 gives a tick every clock. Counter runs in all states.
- Zone update on each tick, with `tempInputDone`=1 and `heat[z]`=1: temp ← min(temp+HEAT_STEP, MAX_TEMP).
- Zone update on each tick, otherwise (including whole IDLE): if temp ≤ AMBIENT+COOL_STEP then temp ← AMBIENT, else temp ← temp−COOL_STEP.
- A zone below AMBIENT cannot be reached. If it were, it clamps to AMBIENT at the next tick.
- All sums are computed at WIDTH+1 bits. No wrap-around is permitted.
- In-band test: temp ≥ targetTemp−TOLERANCE and temp ≤ targetTemp+TOLERANCE. The low bound floors at 0 when targetTemp < TOLERANCE. The high bound is computed at WIDTH+1 bits.
- `allInBand` is the AND of all `zoneInBand` bits.
- FSM states: IDLE, RAMP, SETTLE, READY. Settle counter width is clog2(SETTLE_TICKS+1).
  - IDLE: `preheated`=0, settle count=0. Goes to RAMP when `tempInputDone`=1.
  - RAMP: on a tick with `allInBand`, goes to SETTLE with count=1. If SETTLE_TICKS=1 it goes directly to READY.
  - SETTLE: on a tick with `allInBand`, count increments. It goes to READY when the count reaches SETTLE_TICKS. On a tick with any zone out of band, it goes back to RAMP and clears the count.
  - READY: `preheated`=1. On a tick with any zone out of band, goes to RAMP.
  - Any state with `tempInputDone`=0 goes to IDLE on the next clock, regardless of tick. This override takes priority over the band test.
- The FSM evaluates band flags on pre-update `currentTemp`, that is the values visible during the tick cycle.
- Target change mid-operation: handled by the band test alone. There is no forced restart.

## Timing
- Reset values: every zone = AMBIENT, tick count=0, state IDLE, settle count=0, `preheated`=0, `overTemp`=0. `zoneInBand` follows the combinational result.
- `reset` overrides all other inputs on the same edge.
- Reset mid-operation returns to these values in one clock.
- Temperature latency: `currentTemp` reflects an update one clock after the tick cycle.
- `preheated` latency: rises on the clock edge that ends the SETTLE_TICKS-th consecutive all-in-band tick. It falls on the edge ending the first out-of-band tick, or the first cycle with `tempInputDone`=0.
- With TICK_DIV>1, zones and FSM are static on non-tick clocks, except the IDLE override.

## Test plan
- Reset and idle: assert `reset` for 2 clocks with `heat`=2'b11 and `tempInputDone`=0 → both zones 65, `preheated`=0, `overTemp`=0. Zones stay 65 for 10 further clocks.
- Ramp and settle: defaults, targetTemp=71, `tempInputDone`=1, `heat`=2'b11.
  - Zones go 67, 69, 71 on successive edges.
  - Drop `heat` at 71; zones then go 70, 69.
  - `preheated` rises after 4 consecutive all-in-band ticks.
- Band loss: from READY, hold `heat[1]`=0 until zone1 reaches 68 → `preheated` falls on that tick's edge. State returns to RAMP and a fresh 4-tick settle is required.
- Cool floor and saturation: zone at 66 with `heat`=0 → 65, then stays 65. Zone at 549 with `heat`=1 → 550, then stays 550, and `overTemp`=1 while at 550.
- Abort and tick divider: TICK_DIV=3. Zones update every third clock.
  - Deasserting `tempInputDone` in SETTLE drops state to IDLE within 1 clock and clears the settle count.
  - In IDLE, zones decay 1 per tick.
- Simultaneous events: assert `reset` on the same edge as a tick with `allInBand` in SETTLE → reset values win.
